ps2_player_input_ctrl: RTL and testbench
========================================

// Module: ps2_player_input_ctrl
// PURPOSE
//  Receives PS/2 keyboard frames (oversampled on the system clock) and decodes make/break/extended scan codes.
//  Arbitrates the single key stream between two players (blue = WASD, red = arrow keys) and holds a one-hot direction per player.
//  Sits between the board PS2_CLK/PS2_DAT pins and the game movement logic.
// PARAMETERS
//  FILT_CYC     8        ps2_clk must hold a new level this many clk cycles before it is accepted
//  TIMEOUT_CYC  50000    idle clk cycles allowed between falling edges mid-frame before abort (1 ms @ 50 MHz)
//  BLUE_L/R/U/D 8'h1C/8'h23/8'h1D/8'h1B  blue key codes (non-extended A/D/W/S)
//  RED_L/R/U/D  8'h6B/8'h74/8'h75/8'h72  red key codes (E0-extended arrows)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-high reset
//  ps2_clk    in   1  raw PS/2 clock pin (async)
//  ps2_dat    in   1  raw PS/2 data pin (async)
//  blue_dir   out  4  one-hot {down,up,right,left} for blue; 0 = stopped
//  red_dir    out  4  one-hot {down,up,right,left} for red; 0 = stopped
//  code_byte  out  8  last correctly received byte
//  code_valid out  1  1-cycle pulse: code_byte updated
//  frame_err  out  1  1-cycle pulse: parity/stop/timeout error
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs idle; brk/ext flags 0; filter and timeout counters 0.
//  Input: 2-FF synchroniser on both pins. Filtered ps2_clk changes only after FILT_CYC equal samples.
//    A falling edge is a filtered 1->0 transition; data is sampled in that cycle.
//  Frame FSM (LSB first, 11 bits):
//    RX_IDLE: edge with dat=0 -> RX_DATA, bit count 0; edge with dat=1 -> stay (ignored).
//    RX_DATA: 8 edges shift data bits -> RX_PAR.
//    RX_PAR: store parity bit -> RX_STOP.
//    RX_STOP: dat=1 and odd parity (data+parity has odd 1s) -> accept; else frame_err. Either way -> RX_IDLE.
//    Timeout: in any non-idle state, TIMEOUT_CYC cycles without an edge -> RX_IDLE and frame_err pulse.
//  Latency: stop-bit edge at cycle N -> code_byte/code_valid at N+1 -> dir update visible at N+2.
//  Scan FSM (runs on code_valid):
//    8'hF0 sets brk. 8'hE0 sets ext. No other state change.
//    Any other byte resolves (ext,brk,byte) and then clears both flags.
//    Blue keys match only with ext=0. Red keys match only with ext=1.
//    A matched byte with the wrong ext value is unmapped.
//    Make: set that player's dir to that key's one-hot.
//      Typematic repeat of the same key leaves dir unchanged.
//      A new key overrides the previous one (last pressed wins).
//    Break: if the key equals the player's current dir, dir <= 0; otherwise no change.
//    Unmapped bytes (incl. E1 pause sequence): no dir change, flags cleared.
//    Players are independent: one player's events never alter the other's dir.
//    frame_err clears brk and ext, so a corrupted prefix cannot attach to the next byte.
//  Bytes arrive serially, so no two scan events collide. Reset mid-frame discards the partial frame.
// TESTING
//  Frame 8'h1D (W), good parity -> code_valid 1 cycle, code_byte=8'h1D, blue_dir=4'b0100, red_dir=0.
//  F0,1D after W -> blue_dir=0. F0,1C while holding W -> blue_dir stays 4'b0100.
//  E0,6B -> red_dir=4'b0001. Then 1C -> blue_dir=4'b0001, red_dir unchanged. Then E0,F0,6B -> red_dir=0.
//  8'h1D with a flipped parity bit -> frame_err pulse, no code_valid, blue_dir unchanged.
//    8'h1D with stop bit=0 -> same response.
//  Send start + 4 bits, then stall > TIMEOUT_CYC -> frame_err, FSM idle. Next full frame 8'h23 -> blue_dir=4'b0010.
//  ps2_clk glitch shorter than FILT_CYC mid-frame -> no extra bit; byte decodes correctly.
//    Assert rst mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_player_input_ctrl_if.sv
// PS/2 pin and decoded-direction bundle between board pins,
// the input controller and the game movement logic.
interface ps2_player_input_ctrl_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [3:0] blue_dir;
  logic [3:0] red_dir;
  logic [7:0] code_byte;
  logic       code_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_dat,
    input  blue_dir, red_dir, code_byte, code_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output blue_dir, red_dir, code_byte, code_valid, frame_err
  );
endinterface

// File: rtl/ps2_player_input_ctrl.sv
// PS/2 frame receiver and scan-code decoder that holds a
// one-hot direction for each of two players (WASD / arrows).
module ps2_player_input_ctrl #(
  parameter int         FILT_CYC    = 8,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] BLUE_L = 8'h1C,
  parameter logic [7:0] BLUE_R = 8'h23,
  parameter logic [7:0] BLUE_U = 8'h1D,
  parameter logic [7:0] BLUE_D = 8'h1B,
  parameter logic [7:0] RED_L  = 8'h6B,
  parameter logic [7:0] RED_R  = 8'h74,
  parameter logic [7:0] RED_U  = 8'h75,
  parameter logic [7:0] RED_D  = 8'h72
) (
  input logic clk,
  input logic rst,
  ps2_player_input_ctrl_if.slave bus
);

  localparam int FW = $clog2(FILT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    RX_IDLE, RX_DATA, RX_PAR, RX_STOP
  } rx_e;

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          sclk;
  logic          sdat;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          flip;
  logic          fall;

  rx_e           rx_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    sh_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    byte_q;
  logic          valid_q;
  logic          err_q;

  logic          brk_q;
  logic          ext_q;
  logic [3:0]    blue_q;
  logic [3:0]    red_q;
  logic [3:0]    blue_key;
  logic [3:0]    red_key;

  assign sclk = clk_sync_q[1];
  assign sdat = dat_sync_q[1];

  // Lines idle high, so the synchroniser and filter start there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
      dat_sync_q <= {dat_sync_q[0], bus.ps2_dat};
    end
  end

  assign flip = (sclk != filt_q) &&
                (fcnt_q == FW'(FILT_CYC - 1));
  assign fall = flip && filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (sclk == filt_q) begin
      fcnt_q <= '0;
    end else if (flip) begin
      filt_q <= sclk;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q    <= RX_IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (rx_q == RX_IDLE || fall) tmo_q <= '0;
      else                         tmo_q <= tmo_q + 1'b1;
      if (rx_q != RX_IDLE && !fall &&
          tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        rx_q  <= RX_IDLE;
        err_q <= 1'b1;
      end else if (fall) begin
        unique case (rx_q)
          RX_IDLE: begin
            if (!sdat) begin
              rx_q   <= RX_DATA;
              bcnt_q <= '0;
            end
          end
          RX_DATA: begin
            sh_q   <= {sdat, sh_q[7:1]};
            bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q == 3'd7) rx_q <= RX_PAR;
          end
          RX_PAR: begin
            par_q <= sdat;
            rx_q  <= RX_STOP;
          end
          RX_STOP: begin
            rx_q <= RX_IDLE;
            if (sdat && (^{sh_q, par_q})) begin
              byte_q  <= sh_q;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: rx_q <= RX_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    blue_key = '0;
    unique case (1'b1)
      (byte_q == BLUE_L): blue_key = 4'b0001;
      (byte_q == BLUE_R): blue_key = 4'b0010;
      (byte_q == BLUE_U): blue_key = 4'b0100;
      (byte_q == BLUE_D): blue_key = 4'b1000;
      default:            blue_key = '0;
    endcase
  end

  always_comb begin
    red_key = '0;
    unique case (1'b1)
      (byte_q == RED_L): red_key = 4'b0001;
      (byte_q == RED_R): red_key = 4'b0010;
      (byte_q == RED_U): red_key = 4'b0100;
      (byte_q == RED_D): red_key = 4'b1000;
      default:           red_key = '0;
    endcase
  end

  // A bad frame drops any pending prefix so it cannot
  // attach itself to the next good byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      blue_q <= '0;
      red_q  <= '0;
    end else if (err_q) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
    end else if (valid_q) begin
      if (byte_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else if (byte_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
        if (!ext_q && |blue_key) begin
          if (!brk_q)                 blue_q <= blue_key;
          else if (blue_q == blue_key) blue_q <= '0;
        end
        if (ext_q && |red_key) begin
          if (!brk_q)                red_q <= red_key;
          else if (red_q == red_key) red_q <= '0;
        end
      end
    end
  end

  assign bus.blue_dir   = blue_q;
  assign bus.red_dir    = red_q;
  assign bus.code_byte  = byte_q;
  assign bus.code_valid = valid_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_ps2_player_input_ctrl.sv
// Randomised PS/2 key-stream bench with an event-queue model
// of frames and a table-driven model of the scan decoder.
module tb_ps2_player_input_ctrl;

  localparam int TMO = 2000;
  localparam int H   = 20;

  typedef struct {
    bit         err;
    logic [7:0] b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_player_input_ctrl_if bus();

  ps2_player_input_ctrl #(
    .FILT_CYC(8),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  ev_t        evq[$];
  ev_t        cev;
  int         vec = 0;
  int         bad = 0;
  logic [3:0] m_blue = '0;
  logic [3:0] m_red  = '0;
  logic [7:0] m_byte = '0;
  bit         m_brk  = 0;
  bit         m_ext  = 0;

  logic [7:0] bkeys[4] = '{8'h1C, 8'h23, 8'h1D, 8'h1B};
  logic [7:0] rkeys[4] = '{8'h6B, 8'h74, 8'h75, 8'h72};
  logic [7:0] pool[14] = '{8'h1C, 8'h23, 8'h1D, 8'h1B,
                           8'h6B, 8'h74, 8'h75, 8'h72,
                           8'hF0, 8'hE0, 8'hF0, 8'hE0,
                           8'hE1, 8'h14};

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] lookup(logic [7:0] b,
                                        bit red);
    for (int i = 0; i < 4; i++)
      if ((red ? rkeys[i] : bkeys[i]) == b)
        return 4'(1 << i);
    return 4'b0000;
  endfunction

  task automatic apply(logic [7:0] b);
    logic [3:0] k;
    if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      k = lookup(b, m_ext);
      if (k != 0) begin
        if (m_ext) begin
          if (!m_brk)         m_red = k;
          else if (m_red == k) m_red = '0;
        end else begin
          if (!m_brk)          m_blue = k;
          else if (m_blue == k) m_blue = '0;
        end
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs",
          {bus.blue_dir, bus.red_dir, bus.code_byte,
           bus.code_valid, bus.frame_err}, 0);
      m_blue = '0;
      m_red  = '0;
      m_byte = '0;
      m_brk  = 0;
      m_ext  = 0;
      evq.delete();
    end else begin
      chk("blue_dir", bus.blue_dir, m_blue);
      chk("red_dir", bus.red_dir, m_red);
      if (bus.code_valid || bus.frame_err) begin
        if (evq.size() == 0) begin
          vec++;
          bad++;
          $display("FAIL unexpected_pulse: valid=%0b err=%0b, none pending",
                   bus.code_valid, bus.frame_err);
        end else begin
          cev = evq.pop_front();
          chk("frame_err", bus.frame_err, cev.err);
          chk("code_valid", bus.code_valid, !cev.err);
          if (!cev.err) begin
            chk("code_byte", bus.code_byte, cev.b);
            m_byte = cev.b;
            apply(cev.b);
          end else begin
            m_brk = 0;
            m_ext = 0;
          end
        end
      end else begin
        chk("code_byte_hold", bus.code_byte, m_byte);
      end
    end
  end

  task automatic ticks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(bit v, bit glitch = 0);
    bus.ps2_dat = v;
    ticks(H);
    bus.ps2_clk = 1'b0;
    ticks(H);
    bus.ps2_clk = 1'b1;
    if (glitch) begin
      ticks(12);
      bus.ps2_clk = 1'b0;
      ticks(3);
      bus.ps2_clk = 1'b1;
    end
  endtask

  task automatic send(logic [7:0] b, bit bad_par = 0,
                      bit bad_stop = 0, bit glitch = 0);
    ev_t e;
    e.err = bad_par | bad_stop;
    e.b   = b;
    evq.push_back(e);
    bit_out(0);
    for (int i = 0; i < 8; i++) bit_out(b[i], glitch && i == 3);
    bit_out((~^b) ^ bad_par);
    bit_out(!bad_stop);
    bus.ps2_dat = 1'b1;
    ticks(H);
  endtask

  task automatic drain();
    int n = 0;
    while (evq.size() != 0 && n < 200) begin
      ticks(1);
      n++;
    end
    if (evq.size() != 0) begin
      vec++;
      bad++;
      $display("FAIL drain_timeout: %0d events pending, need 0",
               evq.size());
      evq.delete();
    end
    ticks(3);
  endtask

  task automatic stall_frame();
    ev_t e;
    e.err = 1;
    e.b   = 8'h00;
    evq.push_back(e);
    bit_out(0);
    for (int i = 0; i < 4; i++) bit_out(1);
    ticks(TMO + 200);
  endtask

  initial begin
    #(900_000 * 10);
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         r;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    ticks(4);
    #2 rst = 1'b0;
    ticks(30);

    send(8'h1D); drain();
    chk("w_blue", bus.blue_dir, 4'b0100);
    chk("w_red", bus.red_dir, 4'b0000);
    chk("w_byte", bus.code_byte, 8'h1D);

    send(8'hF0); send(8'h1D); drain();
    chk("w_break", bus.blue_dir, 4'b0000);

    send(8'h1D); send(8'hF0); send(8'h1C); drain();
    chk("other_break", bus.blue_dir, 4'b0100);

    send(8'hE0); send(8'h6B); drain();
    chk("red_left", bus.red_dir, 4'b0001);

    send(8'h1C); drain();
    chk("a_blue", bus.blue_dir, 4'b0001);
    chk("a_red_kept", bus.red_dir, 4'b0001);

    send(8'hE0); send(8'hF0); send(8'h6B); drain();
    chk("red_break", bus.red_dir, 4'b0000);
    chk("red_break_blue", bus.blue_dir, 4'b0001);

    send(8'h1D, 1, 0); drain();
    chk("bad_par_blue", bus.blue_dir, 4'b0001);
    send(8'h1D, 0, 1); drain();
    chk("bad_stop_blue", bus.blue_dir, 4'b0001);

    stall_frame(); drain();
    send(8'h23); drain();
    chk("after_tmo_blue", bus.blue_dir, 4'b0010);

    send(8'h1D, 0, 0, 1); drain();
    chk("glitch_blue", bus.blue_dir, 4'b0100);
    chk("glitch_byte", bus.code_byte, 8'h1D);

    send(8'hF0); send(8'h1D, 1, 0); send(8'h1D); drain();
    chk("err_clears_brk", bus.blue_dir, 4'b0100);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 15);
      if (r < 14) b = pool[r];
      else        b = 8'($urandom);
      if ($urandom_range(0, 9) == 0)
        send(b, $urandom_range(0, 1) == 1, 0);
      else if ($urandom_range(0, 19) == 0)
        send(b, 0, 1);
      else
        send(b);
    end
    drain();

    send(8'h29); send(8'h1C); drain();
    chk("pre_rst_blue", bus.blue_dir, 4'b0001);

    bit_out(0);
    bit_out(1);
    bus.ps2_dat = 1'b0;
    ticks(H);
    bus.ps2_clk = 1'b0;
    ticks(12);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_blue", bus.blue_dir, 4'b0000);
    chk("rst_mid_red", bus.red_dir, 4'b0000);
    chk("rst_mid_byte", bus.code_byte, 8'h00);
    chk("rst_mid_pulses", {bus.code_valid, bus.frame_err}, 2'b00);
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    ticks(5);
    #2 rst = 1'b0;
    ticks(30);

    send(8'h1D); drain();
    chk("post_rst_blue", bus.blue_dir, 4'b0100);
    chk("post_rst_byte", bus.code_byte, 8'h1D);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
